// File: rtl/delta_sigma_pkg.sv
// Shared types and limits for the delta-sigma decimation path.
// Holds the FSM encoding, parameter bounds and result width.
package delta_sigma_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SETTLE = 2'd1,
        ST_RUN    = 2'd2
    } dsd_state_e;

    localparam int OSR_MIN     = 2;
    localparam int OSR_MAX     = 255;
    localparam int DISCARD_MAX = 15;
    localparam int SAMPLE_W    = 8;
    localparam int DISC_W      = 4;

    // Keeps out-of-range parameters inside the range the counters can represent.
    function automatic int clamp_int(input int v, input int lo, input int hi);
        if (v < lo) return lo;
        if (v > hi) return hi;
        return v;
    endfunction

endpackage

// File: rtl/adc_sample_holder.sv
// Single-entry valid/ready result register with drop detection.
// A result that arrives while the entry is full and not being consumed is dropped and flagged.
module adc_sample_holder
    import delta_sigma_pkg::*;
#(
    parameter int W = SAMPLE_W
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         push_valid,
    input  logic [W-1:0] push_data,
    input  logic         pop_ready,
    input  logic         clear_overrun,
    output logic [W-1:0] data,
    output logic         valid,
    output logic         overrun
);

    logic [W-1:0] data_reg, data_next;
    logic         valid_reg, valid_next;
    logic         overrun_reg, overrun_next;
    logic         pop, load, drop;

    always_comb begin
        pop          = valid_reg && pop_ready;
        load         = push_valid && (!valid_reg || pop_ready);
        drop         = push_valid && valid_reg && !pop_ready;
        data_next    = data_reg;
        valid_next   = valid_reg;
        overrun_next = overrun_reg;

        // A load on the same edge as a pop replaces the consumed value.
        if (load) begin
            data_next  = push_data;
            valid_next = 1'b1;
        end else if (pop) begin
            valid_next = 1'b0;
        end

        // A fresh drop outranks a clear arriving on the same edge.
        if (drop) begin
            overrun_next = 1'b1;
        end else if (clear_overrun) begin
            overrun_next = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            data_reg    <= '0;
            valid_reg   <= 1'b0;
            overrun_reg <= 1'b0;
        end else begin
            data_reg    <= data_next;
            valid_reg   <= valid_next;
            overrun_reg <= overrun_next;
        end
    end

    assign data    = data_reg;
    assign valid   = valid_reg;
    assign overrun = overrun_reg;

endmodule

// File: rtl/delta_sigma_decimator.sv
// Sinc1 accumulate-and-dump decimator for a 1-bit delta-sigma bitstream.
// Counts ones over OSR strobed samples, drops DISCARD settling windows, hands results to a holder.
module delta_sigma_decimator
    import delta_sigma_pkg::*;
#(
    parameter int OSR     = 255,
    parameter int DISCARD = 1
) (
    input  logic                clk,
    input  logic                rstN,
    input  logic                enable,
    input  logic                sampleStrobe,
    input  logic                adcInput,
    output logic [SAMPLE_W-1:0] sampleData,
    output logic                sampleValid,
    input  logic                sampleReady,
    output logic                overrun,
    input  logic                clearOverrun
);

    localparam int OSR_EFF     = clamp_int(OSR, OSR_MIN, OSR_MAX);
    localparam int DISCARD_EFF = clamp_int(DISCARD, 0, DISCARD_MAX);
    localparam logic [SAMPLE_W-1:0] WIN_LAST     = SAMPLE_W'(OSR_EFF - 1);
    localparam logic [DISC_W-1:0]   DISCARD_INIT = DISC_W'(DISCARD_EFF);

    dsd_state_e          state_reg, state_next;
    logic [SAMPLE_W-1:0] acc_reg, acc_next;
    logic [SAMPLE_W-1:0] win_cnt_reg, win_cnt_next;
    logic [DISC_W-1:0]   disc_cnt_reg, disc_cnt_next;
    logic [SAMPLE_W-1:0] result;
    logic                accumulate, win_end, push, settle_done;

    // FSM state register
    always_ff @(posedge clk or negedge rstN) begin
        if (!rstN) begin
            state_reg <= ST_IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    // FSM next-state logic
    always_comb begin
        state_next = state_reg;
        if (!enable) begin
            state_next = ST_IDLE;
        end else begin
            case (state_reg)
                ST_IDLE:   state_next = (DISCARD_EFF > 0) ? ST_SETTLE : ST_RUN;
                ST_SETTLE: if (settle_done) state_next = ST_RUN;
                ST_RUN:    state_next = ST_RUN;
                default:   state_next = ST_IDLE;
            endcase
        end
    end

    // FSM outputs: sample qualification and window-end decode
    always_comb begin
        accumulate  = enable && sampleStrobe &&
                      (state_reg == ST_SETTLE || state_reg == ST_RUN);
        win_end     = accumulate && (win_cnt_reg == WIN_LAST);
        result      = acc_reg + {{(SAMPLE_W-1){1'b0}}, adcInput};
        push        = win_end && (state_reg == ST_RUN);
        settle_done = win_end && (state_reg == ST_SETTLE) &&
                      (disc_cnt_reg == DISC_W'(1));
    end

    always_comb begin
        acc_next      = acc_reg;
        win_cnt_next  = win_cnt_reg;
        disc_cnt_next = disc_cnt_reg;
        if (!enable) begin
            acc_next      = '0;
            win_cnt_next  = '0;
            disc_cnt_next = DISCARD_INIT;
        end else if (win_end) begin
            // Clearing here makes the very next strobe sample 0 of the new window.
            acc_next     = '0;
            win_cnt_next = '0;
            if (state_reg == ST_SETTLE && disc_cnt_reg != '0) begin
                disc_cnt_next = disc_cnt_reg - DISC_W'(1);
            end
        end else if (accumulate) begin
            acc_next     = result;
            win_cnt_next = win_cnt_reg + SAMPLE_W'(1);
        end
    end

    always_ff @(posedge clk or negedge rstN) begin
        if (!rstN) begin
            acc_reg      <= '0;
            win_cnt_reg  <= '0;
            disc_cnt_reg <= DISCARD_INIT;
        end else begin
            acc_reg      <= acc_next;
            win_cnt_reg  <= win_cnt_next;
            disc_cnt_reg <= disc_cnt_next;
        end
    end

    adc_sample_holder #(
        .W(SAMPLE_W)
    ) u_holder (
        .clk          (clk),
        .rst_n        (rstN),
        .push_valid   (push),
        .push_data    (result),
        .pop_ready    (sampleReady),
        .clear_overrun(clearOverrun),
        .data         (sampleData),
        .valid        (sampleValid),
        .overrun      (overrun)
    );

endmodule

// File: tb/tb_delta_sigma_decimator.sv
// Directed-vector bench for delta_sigma_decimator with three parameterisations sharing stimulus.
// A: defaults (OSR=255, DISCARD=1); B: OSR=4, DISCARD=0; C: OSR=255, DISCARD=0.
module tb_delta_sigma_decimator;

    logic       clk;
    logic       rstN;
    logic       enable;
    logic       sampleStrobe;
    logic       adcInput;
    logic       sampleReady;
    logic       clearOverrun;

    logic [7:0] a_data, b_data, c_data;
    logic       a_valid, b_valid, c_valid;
    logic       a_ovr, b_ovr, c_ovr;

    int n_checks;
    int n_pass;
    int pulses;
    logic [3:0] pat;

    delta_sigma_decimator dut_a (
        .clk(clk), .rstN(rstN), .enable(enable), .sampleStrobe(sampleStrobe),
        .adcInput(adcInput), .sampleData(a_data), .sampleValid(a_valid),
        .sampleReady(sampleReady), .overrun(a_ovr), .clearOverrun(clearOverrun)
    );

    delta_sigma_decimator #(.OSR(4), .DISCARD(0)) dut_b (
        .clk(clk), .rstN(rstN), .enable(enable), .sampleStrobe(sampleStrobe),
        .adcInput(adcInput), .sampleData(b_data), .sampleValid(b_valid),
        .sampleReady(sampleReady), .overrun(b_ovr), .clearOverrun(clearOverrun)
    );

    delta_sigma_decimator #(.OSR(255), .DISCARD(0)) dut_c (
        .clk(clk), .rstN(rstN), .enable(enable), .sampleStrobe(sampleStrobe),
        .adcInput(adcInput), .sampleData(c_data), .sampleValid(c_valid),
        .sampleReady(sampleReady), .overrun(c_ovr), .clearOverrun(clearOverrun)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input int obs, input int exp);
        n_checks++;
        if (obs == exp) begin
            n_pass++;
            $display("[%0t] %s got=%0d want=%0d ok", $time, tag, obs, exp);
        end else begin
            $display("[%0t] FAIL %s got=%0d want=%0d", $time, tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rstN         = 1'b0;
        enable       = 1'b0;
        sampleStrobe = 1'b0;
        adcInput     = 1'b0;
        sampleReady  = 1'b0;
        clearOverrun = 1'b0;
        step();
        step();
        rstN = 1'b1;
    endtask

    task automatic strobe_once(input logic bit_in);
        sampleStrobe = 1'b1;
        adcInput     = bit_in;
        step();
        sampleStrobe = 1'b0;
        adcInput     = 1'b0;
    endtask

    initial begin
        n_checks = 0;
        n_pass   = 0;

        // Reset values
        do_reset();
        check_eq("rst_a_valid", a_valid, 0);
        check_eq("rst_a_data", a_data, 0);
        check_eq("rst_a_ovr", a_ovr, 0);
        check_eq("rst_b_valid", b_valid, 0);

        // A: all ones, first window discarded, then 0xFF every 255 strobes
        enable = 1'b1;
        step();
        sampleStrobe = 1'b1;
        adcInput     = 1'b1;
        sampleReady  = 1'b1;
        pulses       = 0;
        for (int k = 1; k <= 765; k++) begin
            step();
            if (a_valid) pulses++;
            if (k == 255) check_eq("a_discard_win", a_valid, 0);
            if (k == 509) check_eq("a_before_510", a_valid, 0);
            if (k == 510) begin
                check_eq("a_valid_510", a_valid, 1);
                check_eq("a_data_510", a_data, 255);
            end
            if (k == 511) check_eq("a_handshake", a_valid, 0);
            if (k == 765) begin
                check_eq("a_valid_765", a_valid, 1);
                check_eq("a_data_765", a_data, 255);
            end
        end
        check_eq("a_pulse_count", pulses, 2);

        // C: alternating 1,0,1,... gives 128 / 127 / 128
        do_reset();
        enable      = 1'b1;
        sampleReady = 1'b1;
        step();
        sampleStrobe = 1'b1;
        for (int k = 1; k <= 765; k++) begin
            adcInput = (k % 2 == 1);
            step();
            if (k == 255) begin
                check_eq("c_valid_w1", c_valid, 1);
                check_eq("c_data_w1", c_data, 128);
            end
            if (k == 256) check_eq("c_idle_256", c_valid, 0);
            if (k == 510) check_eq("c_data_w2", c_data, 127);
            if (k == 765) check_eq("c_data_w3", c_data, 128);
        end
        sampleStrobe = 1'b0;
        adcInput     = 1'b0;

        // B: OSR=4, strobe every 3rd cycle, pattern 1,1,0,1
        do_reset();
        enable      = 1'b1;
        sampleReady = 1'b1;
        step();
        pat = 4'b1011;
        for (int i = 0; i < 4; i++) begin
            strobe_once(pat[i]);
            if (i == 2) check_eq("b_latency", b_valid, 0);
            if (i < 3) repeat (2) step();
        end
        check_eq("b_valid_1101", b_valid, 1);
        check_eq("b_data_1101", b_data, 3);
        step();
        check_eq("b_after_hs", b_valid, 0);

        // B: back-pressure across two windows -> overrun
        sampleReady = 1'b0;
        pat = 4'b0011;
        for (int i = 0; i < 4; i++) strobe_once(pat[i]);
        check_eq("b_bp_data1", b_data, 2);
        check_eq("b_bp_ovr1", b_ovr, 0);
        pat = 4'b1111;
        for (int i = 0; i < 4; i++) strobe_once(pat[i]);
        check_eq("b_bp_hold", b_data, 2);
        check_eq("b_bp_valid", b_valid, 1);
        check_eq("b_bp_ovr2", b_ovr, 1);
        clearOverrun = 1'b1;
        step();
        clearOverrun = 1'b0;
        check_eq("b_ovr_clear", b_ovr, 0);
        check_eq("b_clr_hold", b_data, 2);
        sampleReady = 1'b1;
        step();
        check_eq("b_drain", b_valid, 0);

        // B: accept on the same edge as a new result
        sampleReady = 1'b0;
        pat = 4'b0001;
        for (int i = 0; i < 4; i++) strobe_once(pat[i]);
        check_eq("b_sim_first", b_data, 1);
        pat = 4'b0111;
        for (int i = 0; i < 4; i++) begin
            if (i == 3) sampleReady = 1'b1;
            strobe_once(pat[i]);
        end
        check_eq("b_sim_data", b_data, 3);
        check_eq("b_sim_valid", b_valid, 1);
        check_eq("b_sim_ovr", b_ovr, 0);
        step();
        check_eq("b_sim_drain", b_valid, 0);

        // B: enable drops at strobe 2 of 4; next window restarts from zero
        strobe_once(1'b1);
        enable = 1'b0;
        strobe_once(1'b1);
        for (int i = 0; i < 3; i++) strobe_once(1'b1);
        check_eq("b_dis_nout", b_valid, 0);
        enable = 1'b1;
        step();
        pat = 4'b1000;
        for (int i = 0; i < 4; i++) begin
            strobe_once(pat[i]);
            if (i == 2) check_eq("b_reen_early", b_valid, 0);
        end
        check_eq("b_reen_valid", b_valid, 1);
        check_eq("b_reen_data", b_data, 1);
        step();

        // B: asynchronous reset mid-window clears everything at once
        sampleReady = 1'b0;
        pat = 4'b1111;
        for (int i = 0; i < 4; i++) strobe_once(pat[i]);
        for (int i = 0; i < 4; i++) strobe_once(pat[i]);
        check_eq("b_pre_rst_ovr", b_ovr, 1);
        strobe_once(1'b1);
        strobe_once(1'b1);
        rstN = 1'b0;
        #2;
        check_eq("b_arst_valid", b_valid, 0);
        check_eq("b_arst_data", b_data, 0);
        check_eq("b_arst_ovr", b_ovr, 0);
        step();
        rstN        = 1'b1;
        sampleReady = 1'b1;
        step();
        for (int i = 0; i < 4; i++) begin
            strobe_once(1'b1);
            if (i == 2) check_eq("b_post_rst_early", b_valid, 0);
        end
        check_eq("b_post_rst_data", b_data, 4);
        check_eq("b_post_rst_valid", b_valid, 1);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
